// File: rtl/vga_layer_compositor.sv
// Two-stage VGA compositor: fixed-priority sprite select, start/game-over screens, per-frame fade.
// Optional transparent colour key enabled with `define VGA_COLOR_KEY_EN.
module vga_layer_compositor #(
    parameter int                NUM_LAYERS = 13,
    parameter int                PIX_W      = 12,
    parameter int                FADE_MAX   = 15,
    parameter logic [PIX_W-1:0]  KEY_COLOR  = 12'hF0F
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        valid,
    input  logic [1:0]                  state,
    input  logic [NUM_LAYERS-1:0]       layer_exist,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_pixel,
    input  logic [PIX_W-1:0]            pixel_start,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    output logic [PIX_W/3-1:0]          vgaRed,
    output logic [PIX_W/3-1:0]          vgaGreen,
    output logic [PIX_W/3-1:0]          vgaBlue,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        fade_done
);

    localparam int CH_W  = PIX_W / 3;
    localparam int LVL_W = (FADE_MAX < 2) ? 1 : $clog2(FADE_MAX + 1);
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(FADE_MAX);
    localparam logic [1:0] ST_START    = 2'd1;
    localparam logic [1:0] ST_GAMEOVER = 2'd3;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_FADING = 2'd1,
        MODE_FADED  = 2'd2
    } mode_t;

    // Per-channel saturating subtract of the fade level.
    function automatic logic [PIX_W-1:0] fade_pix(input logic [PIX_W-1:0] pix,
                                                  input logic [LVL_W-1:0] lvl);
        logic [PIX_W-1:0] res;
        int ch_val;
        int lv;
        res = '0;
        lv  = int'(lvl);
        for (int c = 0; c < 3; c++) begin
            ch_val = int'(pix[c*CH_W +: CH_W]);
            res[c*CH_W +: CH_W] = (ch_val > lv) ? CH_W'(ch_val - lv) : {CH_W{1'b0}};
        end
        return res;
    endfunction

    logic [NUM_LAYERS-1:0] hit_s;
    logic [PIX_W-1:0]      sel_pix_s;
    logic [PIX_W-1:0]      out_pix_s;
    logic                  vs_fall_s;

    logic                  sel_valid_q;
    logic [PIX_W-1:0]      sel_pix_q;
    logic                  valid_q;
    logic [1:0]            state_q;
    logic [PIX_W-1:0]      pixel_start_q;
    logic                  hsync1_q;
    logic                  vsync1_q;
    logic [PIX_W-1:0]      rgb_q;
    logic                  hsync_q;
    logic                  vsync_q;
    logic                  fade_done_q;
    mode_t                 mode_q, mode_d;
    logic [LVL_W-1:0]      level_q, level_d;

`ifdef VGA_COLOR_KEY_EN
    // Layers showing the key colour are transparent.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            hit_s[i] = layer_exist[i] && (layer_pixel[i*PIX_W +: PIX_W] != KEY_COLOR);
        end
    end
`else
    logic unused_key_s;
    assign unused_key_s = ^KEY_COLOR;

    // Hits come straight from the per-layer flags.
    always_comb begin
        hit_s = layer_exist;
    end
`endif

    // Lowest-index hit wins: scan downward so the last assignment is the winner.
    always_comb begin
        sel_pix_s = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            sel_pix_s = hit_s[i] ? layer_pixel[i*PIX_W +: PIX_W] : sel_pix_s;
        end
    end

    // Stage-2 colour select; fade only applies to the game-over screen.
    always_comb begin
        out_pix_s = '0;
        if (!valid_q) begin
            out_pix_s = '0;
        end else if (state_q == ST_START) begin
            out_pix_s = pixel_start_q;
        end else if (state_q == ST_GAMEOVER) begin
            out_pix_s = fade_pix(sel_valid_q ? sel_pix_q : {PIX_W{1'b0}}, level_q);
        end else if (sel_valid_q) begin
            out_pix_s = sel_pix_q;
        end else begin
            out_pix_s = '0;
        end
    end

    assign vs_fall_s = vsync1_q & ~vsync_in;

    // Fade mode FSM; leaving game over always wins over a vsync edge.
    always_comb begin
        mode_d  = mode_q;
        level_d = level_q;
        if (state != ST_GAMEOVER) begin
            mode_d  = MODE_NORMAL;
            level_d = '0;
        end else begin
            case (mode_q)
                MODE_NORMAL: begin
                    mode_d  = MODE_FADING;
                    level_d = '0;
                end
                MODE_FADING: begin
                    if (level_q == LVL_MAX) begin
                        mode_d = MODE_FADED;
                    end else if (vs_fall_s) begin
                        level_d = level_q + LVL_W'(1);
                        mode_d  = (level_q + LVL_W'(1) == LVL_MAX) ? MODE_FADED : MODE_FADING;
                    end else begin
                        mode_d = MODE_FADING;
                    end
                end
                MODE_FADED: begin
                    mode_d  = MODE_FADED;
                    level_d = LVL_MAX;
                end
                default: begin
                    mode_d  = MODE_NORMAL;
                    level_d = '0;
                end
            endcase
        end
    end

    // Pipeline and FSM registers; syncs idle high in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_valid_q   <= 1'b0;
            sel_pix_q     <= '0;
            valid_q       <= 1'b0;
            state_q       <= 2'd0;
            pixel_start_q <= '0;
            hsync1_q      <= 1'b1;
            vsync1_q      <= 1'b1;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            fade_done_q   <= 1'b0;
            mode_q        <= MODE_NORMAL;
            level_q       <= '0;
        end else begin
            sel_valid_q   <= valid & (|hit_s);
            sel_pix_q     <= sel_pix_s;
            valid_q       <= valid;
            state_q       <= state;
            pixel_start_q <= pixel_start;
            hsync1_q      <= hsync_in;
            vsync1_q      <= vsync_in;
            rgb_q         <= out_pix_s;
            hsync_q       <= hsync1_q;
            vsync_q       <= vsync1_q;
            fade_done_q   <= (mode_d == MODE_FADED);
            mode_q        <= mode_d;
            level_q       <= level_d;
        end
    end

    assign vgaRed    = rgb_q[PIX_W-1 -: CH_W];
    assign vgaGreen  = rgb_q[2*CH_W-1 -: CH_W];
    assign vgaBlue   = rgb_q[CH_W-1:0];
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign fade_done = fade_done_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Table-driven, scoreboarded bench for vga_layer_compositor (13 layers, 12-bit pixels).
module tb_vga_layer_compositor;

    localparam int NL = 13;
    localparam int PW = 12;

    logic            clk;
    logic            rst_n;
    logic            valid;
    logic [1:0]      state;
    logic [NL-1:0]   layer_exist;
    logic [NL*PW-1:0] layer_pixel;
    logic [PW-1:0]   pixel_start;
    logic            hsync_in;
    logic            vsync_in;
    logic [3:0]      vgaRed, vgaGreen, vgaBlue;
    logic            hsync, vsync, fade_done;

    vga_layer_compositor dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .state(state),
        .layer_exist(layer_exist), .layer_pixel(layer_pixel),
        .pixel_start(pixel_start), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .hsync(hsync), .vsync(vsync), .fade_done(fade_done)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        bit          chk_rgb;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        bit          chk_fd;
        logic        fd;
    } exp_t;

    typedef struct {
        logic        v;
        logic [1:0]  st;
        logic [12:0] ex;
        logic [11:0] l0, l1, l2, l3, other;
        logic [11:0] start;
        logic [11:0] rgb;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[12];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [11:0] rgb_out();
        return {vgaRed, vgaGreen, vgaBlue};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic set_layers(input logic [11:0] l0, input logic [11:0] l1, input logic [11:0] l2,
                              input logic [11:0] l3, input logic [11:0] other);
        for (int i = 0; i < NL; i++) begin
            case (i)
                0:       layer_pixel[i*PW +: PW] = l0;
                1:       layer_pixel[i*PW +: PW] = l1;
                2:       layer_pixel[i*PW +: PW] = l2;
                3:       layer_pixel[i*PW +: PW] = l3;
                default: layer_pixel[i*PW +: PW] = other;
            endcase
        end
    endtask

    // One clock: push expectation for the current inputs, compare the one pushed two edges ago.
    task automatic cycle(input bit chk_rgb, input logic [11:0] rgb, input bit chk_fd, input logic fd);
        exp_t e;
        e.chk_rgb = chk_rgb; e.rgb = rgb; e.hs = hsync_in; e.vs = vsync_in;
        e.chk_fd = chk_fd; e.fd = fd;
        sbq.push_back(e);
        @(posedge clk); #1;
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            if (e.chk_rgb) check("rgb", rgb_out(), e.rgb);
            check("hsync", {11'd0, hsync}, {11'd0, e.hs});
            check("vsync", {11'd0, vsync}, {11'd0, e.vs});
            if (e.chk_fd) check("fade_done", {11'd0, fade_done}, {11'd0, e.fd});
        end
    endtask

    task automatic frame();
        vsync_in = 1'b0;
        cycle(1'b0, 12'h000, 1'b0, 1'b0);
        cycle(1'b0, 12'h000, 1'b0, 1'b0);
        vsync_in = 1'b1;
        cycle(1'b0, 12'h000, 1'b0, 1'b0);
        cycle(1'b0, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic reset_cycles(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            valid = 1'($urandom); state = 2'($urandom); layer_exist = 13'($urandom);
            layer_pixel = {5{32'($urandom)}};
            pixel_start = 12'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            @(posedge clk); #1;
            check("rst_rgb", rgb_out(), 12'h000);
            check("rst_hsync", {11'd0, hsync}, 12'h001);
            check("rst_vsync", {11'd0, vsync}, 12'h001);
            check("rst_fade_done", {11'd0, fade_done}, 12'h000);
        end
        sbq.delete();
    endtask

    logic [15:0] hs_pat;
    logic [15:0] vs_pat;
    logic [11:0] key_exp;

    initial begin
`ifdef VGA_COLOR_KEY_EN
        key_exp = 12'h00F;
`else
        key_exp = 12'hF0F;
`endif
        //          v     st    exist             l0      l1      l2      l3      other   start   expected
        vecs[0]  = '{1'b1, 2'd0, 13'b0000000000110, 12'h111, 12'h0F0, 12'hF00, 12'h333, 12'h444, 12'h000, 12'h0F0};
        vecs[1]  = '{1'b1, 2'd0, 13'b0000000000000, 12'h111, 12'h0F0, 12'hF00, 12'h333, 12'h444, 12'h000, 12'h000};
        vecs[2]  = '{1'b1, 2'd1, 13'b0000000000001, 12'hFFF, 12'h0F0, 12'hF00, 12'h333, 12'h444, 12'h123, 12'h123};
        vecs[3]  = '{1'b0, 2'd1, 13'b0000000000001, 12'hFFF, 12'h0F0, 12'hF00, 12'h333, 12'h444, 12'h123, 12'h000};
        vecs[4]  = '{1'b1, 2'd0, 13'b1111111111111, 12'hABC, 12'h0F0, 12'hF00, 12'h333, 12'h444, 12'h123, 12'hABC};
        vecs[5]  = '{1'b1, 2'd2, 13'b1000000000000, 12'hABC, 12'h0F0, 12'hF00, 12'h333, 12'h7E1, 12'h123, 12'h7E1};
        vecs[6]  = '{1'b0, 2'd0, 13'b1111111111111, 12'hABC, 12'h0F0, 12'hF00, 12'h333, 12'h7E1, 12'h123, 12'h000};
        vecs[7]  = '{1'b1, 2'd3, 13'b0000000000000, 12'hABC, 12'h0F0, 12'hF00, 12'h333, 12'h7E1, 12'h123, 12'h000};
        vecs[8]  = '{1'b1, 2'd1, 13'b0000000000000, 12'hABC, 12'h0F0, 12'hF00, 12'h333, 12'h7E1, 12'h456, 12'h456};
        vecs[9]  = '{1'b1, 2'd0, 13'b0000000001001, 12'hF0F, 12'h0F0, 12'hF00, 12'h00F, 12'h7E1, 12'h456, key_exp};
        vecs[10] = '{1'b1, 2'd0, 13'b0000000100000, 12'hF0F, 12'h0F0, 12'hF00, 12'h00F, 12'h321, 12'h456, 12'h321};
        vecs[11] = '{1'b1, 2'd3, 13'b0000000000001, 12'hA5F, 12'h0F0, 12'hF00, 12'h00F, 12'h321, 12'h456, 12'hA5F};

        // Reset with random inputs, then track new inputs two cycles after release.
        reset_cycles(3);
        rst_n = 1'b1; valid = 1'b1; state = 2'd0; hsync_in = 1'b1; vsync_in = 1'b1;
        layer_exist = 13'b0000000000100; set_layers(12'h111, 12'h222, 12'h5A5, 12'h333, 12'h444);
        pixel_start = 12'h000;
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'h5A5, 1'b1, 1'b0);

        // Table: each vector held three cycles while hsync toggles.
        for (int k = 0; k < 12; k++) begin
            valid = vecs[k].v; state = vecs[k].st; layer_exist = vecs[k].ex;
            set_layers(vecs[k].l0, vecs[k].l1, vecs[k].l2, vecs[k].l3, vecs[k].other);
            pixel_start = vecs[k].start;
            for (int c = 0; c < 3; c++) begin
                hsync_in = ~hsync_in;
                cycle(1'b1, vecs[k].rgb, 1'b1, 1'b0);
            end
        end

        // Sync alignment with a known pattern, colour held steady.
        state = 2'd0; layer_exist = 13'b0000000000010; set_layers(12'h111, 12'h9C3, 12'h0, 12'h0, 12'h0);
        hs_pat = 16'b1100_1010_0111_0001;
        vs_pat = 16'b1111_0011_1101_1110;
        for (int i = 0; i < 16; i++) begin
            hsync_in = hs_pat[i]; vsync_in = vs_pat[i];
            cycle(1'b1, 12'h9C3, 1'b1, 1'b0);
        end
        hsync_in = 1'b1; vsync_in = 1'b1;
        cycle(1'b1, 12'h9C3, 1'b1, 1'b0);
        cycle(1'b1, 12'h9C3, 1'b1, 1'b0);

        // Fade to black on game over.
        state = 2'd3; layer_exist = 13'b0000000000001; set_layers(12'hA5F, 12'h0, 12'h0, 12'h0, 12'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 12'hA5F, 1'b1, 1'b0);
        for (int f = 0; f < 6; f++) frame();
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'h409, 1'b1, 1'b0);
        for (int f = 0; f < 9; f++) frame();
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'h000, 1'b1, 1'b1);
        frame();
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'h000, 1'b1, 1'b1);
        cycle(1'b1, 12'h000, 1'b0, 1'b0);
        state = 2'd0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'hA5F, 1'b1, 1'b0);

        // Refade fully, then reset mid-frame: fade level must restart from zero.
        state = 2'd3;
        for (int i = 0; i < 2; i++) cycle(1'b1, 12'hA5F, 1'b1, 1'b0);
        for (int f = 0; f < 15; f++) frame();
        for (int i = 0; i < 2; i++) cycle(1'b1, 12'h000, 1'b1, 1'b1);
        reset_cycles(2);
        rst_n = 1'b1; valid = 1'b1; state = 2'd3; hsync_in = 1'b0; vsync_in = 1'b1;
        layer_exist = 13'b0000000000001; set_layers(12'hA5F, 12'h0, 12'h0, 12'h0, 12'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 12'hA5F, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_layer_compositor.md
Name: vga_layer_compositor

Overview:
Parametrised, pipelined successor to the combinational VGA pixel priority mux. Selects one pixel per cycle from NUM_LAYERS sprite layers using fixed index priority, overlays start and game-over screens by game state, and applies a per-frame fade-to-black on game over. Sits between the sprite/ROM pixel generators and the VGA pins. Re-times hsync/vsync so they stay aligned with the colour outputs.

Parameters:
NUM_LAYERS, 13, number of sprite layers; layer 0 has the highest priority.
PIX_W, 12, pixel width in bits (4R:4G:4B); must be a multiple of 3.
FADE_MAX, 15, final fade level; fade steps are applied once per frame.
KEY_COLOR, 12'hF0F, transparent colour key; used only when VGA_COLOR_KEY_EN is defined.

Ports:
clk  in  1  pixel clock (25 MHz)
rst_n  in  1  synchronous, active-low reset
valid  in  1  active-video flag for the current pixel
state  in  2  game state: 0 = play, 1 = start screen, 2 = play (paused), 3 = game over
layer_exist  in  NUM_LAYERS  per-layer hit flags for the current pixel
layer_pixel  in  NUM_LAYERS*PIX_W  flattened layer colours; layer i occupies bits [i*PIX_W +: PIX_W]
pixel_start  in  PIX_W  start-screen colour
hsync_in  in  1  horizontal sync from the timing generator
vsync_in  in  1  vertical sync from the timing generator (active-low pulse)
vgaRed  out  PIX_W/3  red channel (registered)
vgaGreen  out  PIX_W/3  green channel (registered)
vgaBlue  out  PIX_W/3  blue channel (registered)
hsync  out  1  hsync_in delayed by 2 cycles
vsync  out  1  vsync_in delayed by 2 cycles
fade_done  out  1  high when fade_level == FADE_MAX while in state 3

Behaviour:
- Reset (rst_n == 0 at a clk edge): all outputs 0 except hsync = 1 and vsync = 1; both pipeline stages cleared; fade_level = 0; mode FSM = NORMAL.
- Latency: fixed at 2 cycles for colour and syncs. Inputs at edge N appear on the outputs after edge N+2. No stalls.
- Stage 1 (registered):
  - sel_valid = valid & |layer_exist.
  - sel_pix = layer_pixel of the lowest set index.
  - Also registers valid, state, pixel_start, hsync_in and vsync_in.
- Stage 2 (registered), evaluated in this order:
  - !valid → 0.
  - state == 1 → pixel_start.
  - state == 3 → sel_pix when sel_valid, else 0; then fade is applied.
  - sel_valid → sel_pix.
  - Otherwise → 0.
- Fade:
  - Each channel is output as max(channel − fade_level, 0), computed with a saturating subtract at channel width.
  - Fade is applied only when the registered state == 3.
- Mode FSM:
  - States: NORMAL, FADING, FADED.
  - NORMAL → FADING when state == 3; fade_level ← 0 on that transition.
  - FADING: fade_level increments by 1 on each vsync_in falling edge, detected from a registered previous value of vsync_in.
  - FADING → FADED when fade_level reaches FADE_MAX; the count saturates there.
  - Any state → NORMAL whenever state != 3; fade_level ← 0 immediately.
- Simultaneous events: if state leaves 3 on the same cycle as a vsync edge, the return to NORMAL wins.
- fade_done is registered and equals (FSM == FADED).
- Boundaries:
  - No layer hit → background black.
  - All layers hit → layer 0 wins.
  - NUM_LAYERS = 1 is legal.
- Reset mid-frame: the pipeline is flushed to zeros, and outputs follow the new inputs 2 cycles after rst_n rises.

Optional Feature:
VGA_COLOR_KEY_EN
- Defined: a layer whose pixel equals KEY_COLOR is treated as not hit, so priority falls through to the next set layer. A layer pixel equal to KEY_COLOR never reaches the output.
- Undefined: KEY_COLOR is ignored and layer_exist alone decides hits, giving identical behaviour to the plain priority mux.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with random inputs → RGB = 0, hsync = vsync = 1, fade_done = 0; 2 cycles after release, outputs track the inputs.
2. Priority: valid = 1, state = 0, layer_exist = 13'b0000000000110, layer1 = 12'h0F0, layer2 = 12'hF00 → output 12'h0F0 exactly 2 cycles later; with layer_exist = 0 → 12'h000.
3. Screens: state = 1, pixel_start = 12'h123, layer0 hit with 12'hFFF → output 12'h123. Then valid = 0 → output 12'h000.
4. Fade: state = 3, layer0 = 12'hA5F hit. After 0 frames → 12'hA5F; after 6 vsync falling edges → 12'h409; after 15 edges → 12'h000 and fade_done = 1. Set state = 0 → output 12'hA5F and fade_done = 0 on the next pass.
5. Sync alignment: toggle hsync_in/vsync_in with a known pattern → hsync/vsync reproduce it delayed by exactly 2 cycles, in phase with colour.
6. (VGA_COLOR_KEY_EN) layer0 = 12'hF0F and layer3 = 12'h00F, both hit → output 12'h00F. With the macro undefined, the same stimulus gives 12'hF0F.
